// File: rtl/key_debounce_if.sv
// key_debounce_if
//   Bundles the raw key line and the debounced key outputs of key_debounce.
//
//   Signals:
//     key_in      raw mechanical key, asynchronous, low = pressed
//     key_level   debounced level, 1 = released, 0 = pressed
//     key_press   single-cycle pulse on each debounced press
//     key_release single-cycle pulse on each debounced release
//     key_long    single-cycle pulse when a press lasts the long threshold
//
//   Modports:
//     master  the side that owns the key (board pin / bench) and sees results
//     slave   the debouncer itself
interface key_debounce_if;
  logic key_in;
  logic key_level;
  logic key_press;
  logic key_release;
  logic key_long;

  modport master (
    output key_in,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_long
  );

  modport slave (
    input  key_in,
    output key_level,
    output key_press,
    output key_release,
    output key_long
  );
endinterface

// File: rtl/key_debounce.sv
// key_debounce
//   Debounces an active-low mechanical key. The raw input is synchronized,
//   then a four-state FSM qualifies each level change for DEBOUNCE_CYCLES
//   consecutive samples before accepting it. A hold counter measures how
//   long a qualified press lasts and flags a long press once per press.
//
//   Parameters:
//     DEBOUNCE_CYCLES  stable-level qualification time in clk cycles (2..2^24-1)
//     LONG_CYCLES      long-press threshold in clk cycles from key_press (2..2^24-1)
//
//   Ports:
//     clk      rising-edge clock for all state
//     rst_n    asynchronous, active-low reset
//     key_bus  slave side of key_debounce_if (key_in in, debounced outputs out)
//
//   All outputs are registered.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned LONG_CYCLES     = 12000000
) (
  input  logic          clk,
  input  logic          rst_n,
  key_debounce_if.slave key_bus
);

  localparam logic [23:0] DB_LAST   = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] LONG_LAST = 24'(LONG_CYCLES - 1);
  localparam logic [23:0] LONG_SAT  = 24'(LONG_CYCLES);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_e;

  // Synchronizer: bit 0 is the first flop, bit 1 the second.
  logic [1:0]  sync_q, sync_d;
  logic        ks;

  state_e      state_q, state_d;
  logic [23:0] db_cnt_q, db_cnt_d;
  logic [23:0] hold_cnt_q, hold_cnt_d;

  logic        level_q, level_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        long_q, long_d;

  logic        enter_held;
  logic        enter_idle;
  logic        in_hold;

  // Two-flop synchronizer; both flops reset to the released level so a
  // key held down through reset still has to be qualified afterwards.
  always_comb begin
    sync_d = {sync_q[0], key_bus.key_in};
  end

  assign ks = sync_q[1];

  // State register and all other flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b11;
      state_q    <= IDLE;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b1;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

  // Next-state logic with the debounce counter. A sample that disagrees
  // with the level being qualified drops straight back to the stable
  // state, so only an unbroken run of DEBOUNCE_CYCLES+1 samples counts.
  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    case (state_q)
      IDLE: begin
        if (!ks) begin
          state_d  = DB_PRESS;
          db_cnt_d = '0;
        end
      end
      DB_PRESS: begin
        if (ks) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = HELD;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + 24'd1;
        end
      end
      HELD: begin
        if (ks) begin
          state_d  = DB_RELEASE;
          db_cnt_d = '0;
        end
      end
      DB_RELEASE: begin
        if (!ks) begin
          state_d  = HELD;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + 24'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  // Hold counter. It is cleared only when a press is qualified, not when a
  // release bounce returns to HELD, so a bounce neither restarts the long
  // timer nor allows a second key_long. Saturating keeps the LONG_LAST
  // match a one-time event per press.
  always_comb begin
    enter_held = (state_q == DB_PRESS)   && (state_d == HELD);
    enter_idle = (state_q == DB_RELEASE) && (state_d == IDLE);
    in_hold    = (state_q == HELD) || (state_q == DB_RELEASE);

    hold_cnt_d = hold_cnt_q;
    if (enter_held) begin
      hold_cnt_d = '0;
    end else if (in_hold && (hold_cnt_q != LONG_SAT)) begin
      hold_cnt_d = hold_cnt_q + 24'd1;
    end
  end

  // Output logic, registered one edge later so each pulse appears in the
  // cycle after its transition. A release qualified on the same edge as
  // the long threshold wins and the long pulse is dropped.
  always_comb begin
    press_d   = enter_held;
    release_d = enter_idle;
    long_d    = in_hold && (hold_cnt_q == LONG_LAST) && !enter_idle;
    level_d   = !((state_d == HELD) || (state_d == DB_RELEASE));
  end

  assign key_bus.key_level   = level_q;
  assign key_bus.key_press   = press_q;
  assign key_bus.key_release = release_q;
  assign key_bus.key_long    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce
//   Bench for key_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
//   A timeline model derives expected outputs from the raw key history:
//   a level change is accepted after an unbroken run of DB+1 synchronized
//   samples of the opposite level, and a long press is due LONG edges
//   after the accepted press unless the key is accepted as released first.
//   Directed scenarios add hand-computed latency and pulse-count checks.
module tb_key_debounce;

  localparam int unsigned DB   = 4;
  localparam int unsigned LONG = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  key_debounce_if key_bus ();

  key_debounce #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LONG)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_bus(key_bus)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc equals the number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // Model state.
  logic m_s1 = 1'b1;
  logic m_s2 = 1'b1;
  logic m_level = 1'b1;
  int   m_run = 0;
  int   m_since_press = 0;
  logic m_long_due = 1'b0;
  logic exp_press = 1'b0;
  logic exp_release = 1'b0;
  logic exp_long = 1'b0;

  initial begin
    logic ks;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_s1 = 1'b1;  m_s2 = 1'b1;  m_level = 1'b1;
        m_run = 0;    m_since_press = 0;  m_long_due = 1'b0;
        exp_press = 1'b0;  exp_release = 1'b0;  exp_long = 1'b0;
      end else begin
        ks   = m_s2;
        m_s2 = m_s1;
        m_s1 = key_bus.key_in;
        exp_press = 1'b0;  exp_release = 1'b0;  exp_long = 1'b0;
        if (ks != m_level) m_run++;
        else               m_run = 0;
        if (m_run == int'(DB) + 1) begin
          m_level = ks;
          m_run   = 0;
          if (!m_level) begin
            exp_press     = 1'b1;
            m_since_press = 0;
            m_long_due    = 1'b1;
          end else begin
            exp_release = 1'b1;
            m_long_due  = 1'b0;
          end
        end else if (!m_level && m_long_due) begin
          m_since_press++;
          if (m_since_press == int'(LONG)) begin
            exp_long   = 1'b1;
            m_long_due = 1'b0;
          end
        end
      end
    end
  end

  // Pulse bookkeeping for the directed checks.
  int press_cnt = 0, release_cnt = 0, long_cnt = 0;
  int last_press = -1000, last_release = -1000, last_long = -1000;

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("key_level",   key_bus.key_level,   m_level);
      checkOutput("key_press",   key_bus.key_press,   exp_press);
      checkOutput("key_release", key_bus.key_release, exp_release);
      checkOutput("key_long",    key_bus.key_long,    exp_long);
      checkOutput("pulse_overlap",
                  (int'(key_bus.key_press) + int'(key_bus.key_release) +
                   int'(key_bus.key_long)) > 1, 0);
      if (key_bus.key_press === 1'b1)   begin press_cnt++;   last_press = cyc;   end
      if (key_bus.key_release === 1'b1) begin release_cnt++; last_release = cyc; end
      if (key_bus.key_long === 1'b1)    begin long_cnt++;    last_long = cyc;    end
    end
  end

  // Drive key_in at a negedge and let it sit for the given number of cycles.
  task automatic applyStimulus(input logic level, input int cycles);
    key_bus.key_in = level;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int t0, tf, tr, np, nr, nl;

    key_bus.key_in = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    $display("[TB] reset state before first clock edge");
    checkOutput("reset_level",   key_bus.key_level,   1);
    checkOutput("reset_press",   key_bus.key_press,   0);
    checkOutput("reset_release", key_bus.key_release, 0);
    checkOutput("reset_long",    key_bus.key_long,    0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 4);

    $display("[TB] clean press");
    np = press_cnt;
    t0 = cyc + 1;
    applyStimulus(1'b0, 8);
    checkOutput("press_latency", last_press - t0, 6);
    checkOutput("press_count",   press_cnt - np, 1);
    checkOutput("press_level",   key_bus.key_level, 0);

    $display("[TB] short release");
    nr = release_cnt;  nl = long_cnt;
    t0 = cyc + 1;
    applyStimulus(1'b1, 12);
    checkOutput("release_latency", last_release - t0, 6);
    checkOutput("release_count",   release_cnt - nr, 1);
    checkOutput("short_no_long",   long_cnt - nl, 0);
    checkOutput("release_level",   key_bus.key_level, 1);

    $display("[TB] bounce then long press");
    np = press_cnt;  nl = long_cnt;
    applyStimulus(1'b0, 3);
    applyStimulus(1'b1, 2);
    tf = cyc + 1;
    applyStimulus(1'b0, 30);
    checkOutput("bounce_press_count",   press_cnt - np, 1);
    checkOutput("bounce_press_latency", last_press - tf, 6);
    checkOutput("long_count",           long_cnt - nl, 1);
    checkOutput("long_after_press",     last_long - last_press, 10);
    nr = release_cnt;
    t0 = cyc + 1;
    applyStimulus(1'b1, 12);
    checkOutput("long_release_latency", last_release - t0, 6);
    checkOutput("long_release_count",   release_cnt - nr, 1);
    checkOutput("long_once",            long_cnt - nl, 1);

    $display("[TB] release coincides with long threshold");
    nr = release_cnt;  nl = long_cnt;
    applyStimulus(1'b0, 10);
    applyStimulus(1'b1, 12);
    checkOutput("coincide_gap",     last_release - last_press, 10);
    checkOutput("coincide_release", release_cnt - nr, 1);
    checkOutput("coincide_no_long", long_cnt - nl, 0);

    $display("[TB] release bounce keeps hold time");
    nr = release_cnt;  nl = long_cnt;
    applyStimulus(1'b0, 8);
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 14);
    checkOutput("rbounce_no_release", release_cnt - nr, 0);
    checkOutput("rbounce_long_count", long_cnt - nl, 1);
    checkOutput("rbounce_long_gap",   last_long - last_press, 10);
    applyStimulus(1'b1, 12);
    checkOutput("rbounce_release", release_cnt - nr, 1);

    $display("[TB] reset mid-debounce");
    np = press_cnt;
    key_bus.key_in = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_db_reset_level", key_bus.key_level, 1);
    checkOutput("mid_db_reset_press", key_bus.key_press, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tr = cyc + 1;
    repeat (10) @(negedge clk);
    checkOutput("post_reset_press_count",   press_cnt - np, 1);
    checkOutput("post_reset_press_latency", last_press - tr, 6);

    $display("[TB] reset mid-hold");
    nr = release_cnt;  nl = long_cnt;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_hold_reset_level", key_bus.key_level, 1);
    key_bus.key_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 20);
    checkOutput("mid_hold_no_release", release_cnt - nr, 0);
    checkOutput("mid_hold_no_long",    long_cnt - nl, 0);

    $display("[TB] glitch filter");
    np = press_cnt;  nr = release_cnt;  nl = long_cnt;
    for (int i = 0; i < 100; i++) begin
      applyStimulus((i % 3 == 0) ? 1'b0 : 1'b1, 1);
    end
    applyStimulus(1'b1, 10);
    checkOutput("glitch_pulses",
                (press_cnt - np) + (release_cnt - nr) + (long_cnt - nl), 0);
    checkOutput("glitch_level", key_bus.key_level, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 240000, SHALL set the stable-level qualification time in clk cycles (20 ms at 12 MHz); legal range 2..2^24-1.
REQ-002 Parameter LONG_CYCLES, default 12000000, SHALL set the long-press threshold in clk cycles measured from key_press (1 s at 12 MHz); legal range 2..2^24-1.
REQ-003 clk  input  1  12 MHz board clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 key_in  input  1  raw mechanical key, asynchronous, low = pressed.
REQ-006 key_level  output  1  debounced key level, 1 = released, 0 = pressed.
REQ-007 key_press  output  1  single-cycle pulse on each debounced press.
REQ-008 key_release  output  1  single-cycle pulse on each debounced release.
REQ-009 key_long  output  1  single-cycle pulse, at most once per press, when the press lasts LONG_CYCLES.

Function
REQ-010 key_in SHALL pass through a two-flop synchronizer; only the second-flop value (ks) SHALL be used by later logic.
REQ-011 The FSM SHALL have exactly four states: IDLE (stable released), DB_PRESS, HELD (stable pressed), DB_RELEASE.
REQ-012 IDLE: ks=0 -> DB_PRESS with debounce counter cleared to 0; otherwise stay.
REQ-013 DB_PRESS: ks=1 -> IDLE, counter cleared, no pulse; ks=0 and counter=DEBOUNCE_CYCLES-1 -> HELD; otherwise counter+1.
REQ-014 HELD: ks=1 -> DB_RELEASE with debounce counter cleared; otherwise stay.
REQ-015 DB_RELEASE: ks=0 -> HELD, counter cleared, no pulse; ks=1 and counter=DEBOUNCE_CYCLES-1 -> IDLE; otherwise counter+1.
REQ-016 All outputs SHALL be registered; key_press SHALL be 1 for exactly the one cycle following the DB_PRESS->HELD edge, key_release likewise for DB_RELEASE->IDLE.
REQ-017 Latency: with key_in held low, the FSM enters HELD on the clock edge DEBOUNCE_CYCLES+2 edges after the edge that first samples key_in low (edge 0); key_press SHALL be high during the cycle after edge DEBOUNCE_CYCLES+2. Release latency SHALL be identical.
REQ-018 key_level SHALL be 0 while state is HELD or DB_RELEASE and 1 while IDLE or DB_PRESS, changing on the same edge as the state.
REQ-019 A hold counter SHALL clear on entry to HELD and increment each cycle in HELD or DB_RELEASE, saturating at LONG_CYCLES.
REQ-020 key_long SHALL pulse for one cycle when the hold counter reaches LONG_CYCLES-1; a release bounce (HELD->DB_RELEASE->HELD) SHALL NOT clear the hold counter nor re-arm key_long.
REQ-021 Any glitch shorter than DEBOUNCE_CYCLES SHALL produce no pulse and no key_level change.
REQ-022 key_press, key_release, key_long SHALL never be high in the same cycle; if the long threshold and release qualification coincide, key_release SHALL be emitted and key_long suppressed.
REQ-023 Both counters SHALL be 24 bits wide and never wrap.

Reset
REQ-024 On rst_n=0, immediately and independently of clk: state=IDLE, both synchronizer flops=1, both counters=0, key_level=1, key_press=key_release=key_long=0.
REQ-025 Reset asserted in any state, including mid-debounce or mid-hold, SHALL abort without emitting any pulse; after release the block SHALL restart from IDLE and require a full qualification.
REQ-026 After rst_n deasserts with key_in already low, the block SHALL qualify it as a normal new press (key_press per REQ-017).

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10)
REQ-027 Clean press: key_in 1->0 sampled at edge 0, held -> key_press=1 only in cycle after edge 6, key_level 0 from edge 6.
REQ-028 Bounce: key_in low 3 cycles, high 2, then low steady -> no pulse from the first 3-cycle low; exactly one key_press, 6 edges after the final falling sample.
REQ-029 Long press: key_in held low 30 cycles -> key_press once, key_long once exactly 10 cycles after key_press, then no further pulses until release.
REQ-030 Release: after REQ-027, key_in 0->1 held -> key_release single pulse 6 edges after first high sample, key_level returns to 1 on that edge, key_long absent if held under 10 cycles.
REQ-031 Reset mid-debounce: key_in low, rst_n pulsed low at edge 3 for 2 cycles -> all outputs at reset values asynchronously, no key_press until a fresh 6-edge qualification after rst_n rises.
REQ-032 Glitch filter: single-cycle low spikes on key_in every 3 cycles for 100 cycles -> key_level stays 1, zero pulses.
